// File: rtl/cpu_step_ctrl_pkg.sv
// rtl/cpu_step_ctrl_pkg.sv - shared types and constants for the CPU step controller
package cpu_step_ctrl_pkg;

    localparam int RATIO_W = 32;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // A ratio of zero would never tick, so it is promoted to one.
    function automatic logic [RATIO_W-1:0] norm_ratio(input logic [RATIO_W-1:0] r);
        return (r == '0) ? RATIO_W'(1) : r;
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// rtl/cpu_step_ctrl_if.sv - control/status bundle between the step controller and its host
interface cpu_step_ctrl_if;
    import cpu_step_ctrl_pkg::*;

    logic               run_sw;
    logic               step_btn;
    logic               halt_req;
    logic               ratio_load;
    logic [RATIO_W-1:0] ratio_value;
    logic               cpu_en;
    logic [1:0]         state;

    modport master (
        output run_sw, step_btn, halt_req, ratio_load, ratio_value,
        input  cpu_en, state
    );

    modport slave (
        input  run_sw, step_btn, halt_req, ratio_load, ratio_value,
        output cpu_en, state
    );

endinterface

// File: rtl/cpu_step_ctrl_step_debounce.sv
// rtl/cpu_step_ctrl_step_debounce.sv - step button synchronizer, optional debounce (CPU_STEP_CTRL_DEBOUNCE_EN), press pulse
module step_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic n_reset,
    input  logic btn,
    output logic press
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

`ifdef CPU_STEP_CTRL_DEBOUNCE_EN
    localparam int DB_LAST = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam int DB_W    = (DB_LAST > 0) ? $clog2(DB_LAST + 1) : 1;

    logic [DB_W-1:0] db_cnt;

    // The level only follows sync2 after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_LAST)) begin
            db_cnt <= '0;
            level  <= sync2;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end
`else
    logic unused_db;

    assign unused_db = (DEBOUNCE_CYCLES > 0);
    assign level     = sync2;
`endif

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - CPU run/step/halt enable generator; CPU_STEP_CTRL_DEBOUNCE_EN enables step debounce
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int RATIO           = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic           clock,
    input  logic           n_reset,
    cpu_step_ctrl_if.slave bus
);

    localparam logic [RATIO_W-1:0] RATIO_RST = norm_ratio(RATIO_W'(RATIO));

    state_t             cur_state;
    state_t             nxt_state;
    logic [RATIO_W-1:0] ratio;
    logic [RATIO_W-1:0] count;
    logic [RATIO_W-1:0] count_nxt;
    logic               tick;
    logic               en;
    logic               press;

    step_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clock   (clock),
        .n_reset (n_reset),
        .btn     (bus.step_btn),
        .press   (press)
    );

    assign tick = (count == ratio - RATIO_W'(1));

    // The counter only advances while staying in RUN; any exit or ratio load zeroes it.
    always_comb begin
        nxt_state = cur_state;
        en        = 1'b0;
        count_nxt = '0;
        case (cur_state)
            ST_STOP: begin
                if (bus.run_sw)
                    nxt_state = ST_RUN;
                else if (press)
                    nxt_state = ST_STEP;
            end
            ST_RUN: begin
                if (bus.halt_req)
                    nxt_state = ST_HALT;
                else if (!bus.run_sw)
                    nxt_state = ST_STOP;
                else if (!bus.ratio_load) begin
                    en        = tick;
                    count_nxt = tick ? '0 : count + RATIO_W'(1);
                end
            end
            ST_STEP: begin
                en        = 1'b1;
                nxt_state = bus.halt_req ? ST_HALT : ST_STOP;
            end
            ST_HALT: begin
                if (!bus.run_sw)
                    nxt_state = ST_STOP;
            end
            default: nxt_state = ST_STOP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            cur_state <= ST_STOP;
            count     <= '0;
            ratio     <= RATIO_RST;
        end else begin
            cur_state <= nxt_state;
            count     <= count_nxt;
            if (bus.ratio_load)
                ratio <= norm_ratio(bus.ratio_value);
        end
    end

    assign bus.cpu_en = en;
    assign bus.state  = cur_state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - directed self-checking bench for cpu_step_ctrl
module tb_cpu_step_ctrl;

    logic clock = 1'b0;
    logic n_reset;
    int   total = 0;
    int   bad   = 0;

    cpu_step_ctrl_if bus();

    cpu_step_ctrl #(
        .RATIO           (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            cyc();
            if (bus.cpu_en) pulses++;
        end
    endtask

    int p1, p2;
    int seen_halt;
    logic prev_en;

    initial begin
        n_reset         = 1'b0;
        bus.run_sw      = 1'b1;
        bus.step_btn    = 1'b1;
        bus.halt_req    = 1'b1;
        bus.ratio_load  = 1'b1;
        bus.ratio_value = 32'd7;
        cyc();
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_en", 32'(bus.cpu_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_hold_state", 32'(bus.state), 32'd0);
            check("rst_hold_en", 32'(bus.cpu_en), 32'd0);
        end

        bus.run_sw      = 1'b0;
        bus.step_btn    = 1'b0;
        bus.halt_req    = 1'b0;
        bus.ratio_load  = 1'b0;
        bus.ratio_value = 32'd0;
        n_reset         = 1'b1;
        repeat (3) cyc();
        check("idle_state", 32'(bus.state), 32'd0);

        // free run at the reset ratio of 2
        bus.run_sw = 1'b1;
        cyc();
        check("run_enter_state", 32'(bus.state), 32'd1);
        check("run_enter_en", 32'(bus.cpu_en), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check("r2_en", 32'(bus.cpu_en), (k % 2 == 1) ? 32'd1 : 32'd0);
        end

        // reload to 5 while running
        bus.ratio_load  = 1'b1;
        bus.ratio_value = 32'd5;
        cyc();
        bus.ratio_load  = 1'b0;
        check("load_clr_en", 32'(bus.cpu_en), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            check("r5_en", 32'(bus.cpu_en), (k % 5 == 4) ? 32'd1 : 32'd0);
        end

        // a load on a tick cycle suppresses that tick; ratio 0 acts as 1
        bus.ratio_load  = 1'b1;
        bus.ratio_value = 32'd0;
        #1;
        check("load_suppress", 32'(bus.cpu_en), 32'd0);
        cyc();
        bus.ratio_load = 1'b0;
        #1;
        check("r1_en", 32'(bus.cpu_en), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("r1_en", 32'(bus.cpu_en), 32'd1);
        end

        // halt wins over stop; no enable in the transition cycle
        bus.halt_req = 1'b1;
        bus.run_sw   = 1'b0;
        #1;
        check("trans_no_en", 32'(bus.cpu_en), 32'd0);
        cyc();
        check("halt_state", 32'(bus.state), 32'd3);
        check("halt_en", 32'(bus.cpu_en), 32'd0);
        bus.halt_req = 1'b0;
        cyc();
        check("halt_to_stop", 32'(bus.state), 32'd0);

        bus.ratio_load  = 1'b1;
        bus.ratio_value = 32'd3;
        cyc();
        bus.ratio_load  = 1'b0;

        // reset on a tick cycle in RUN
        bus.run_sw = 1'b1;
        cyc();
        cyc();
        cyc();
        check("pre_rst_tick", 32'(bus.cpu_en), 32'd1);
        n_reset = 1'b0;
        cyc();
        check("rst_abort_en", 32'(bus.cpu_en), 32'd0);
        check("rst_abort_state", 32'(bus.state), 32'd0);
        n_reset = 1'b1;
        cyc();
        check("post_rst_run", 32'(bus.state), 32'd1);
        check("post_rst_c0", 32'(bus.cpu_en), 32'd0);
        cyc();
        check("ratio_reset_tick", 32'(bus.cpu_en), 32'd1);
        bus.run_sw = 1'b0;
        cyc();
        check("back_to_stop", 32'(bus.state), 32'd0);

`ifdef CPU_STEP_CTRL_DEBOUNCE_EN
        bus.step_btn = 1'b1;
        cyc();
        bus.step_btn = 1'b0;
        count_pulses(12, p1);
        check("glitch_no_pulse", 32'(p1), 32'd0);
`else
        bus.step_btn = 1'b1;
        cyc();
        bus.step_btn = 1'b0;
        cyc();
        check("pulse_lat1", 32'(bus.cpu_en), 32'd0);
        cyc();
        check("pulse_lat2", 32'(bus.cpu_en), 32'd0);
        cyc();
        check("pulse_lat3_en", 32'(bus.cpu_en), 32'd1);
        check("pulse_lat3_state", 32'(bus.state), 32'd2);
        cyc();
        check("pulse_after_en", 32'(bus.cpu_en), 32'd0);
        check("pulse_after_state", 32'(bus.state), 32'd0);
`endif

        // held button gives exactly one step
        bus.step_btn = 1'b1;
        count_pulses(20, p1);
        bus.step_btn = 1'b0;
        count_pulses(8, p2);
        check("held_one_pulse", 32'(p1 + p2), 32'd1);
        check("held_end_state", 32'(bus.state), 32'd0);

        // presses in HALT are dropped
        bus.run_sw   = 1'b1;
        bus.halt_req = 1'b1;
        cyc();
        cyc();
        check("run_to_halt", 32'(bus.state), 32'd3);
        bus.step_btn = 1'b1;
        count_pulses(8, p1);
        bus.step_btn = 1'b0;
        count_pulses(10, p2);
        check("halt_drops_press", 32'(p1 + p2), 32'd0);
        check("halt_stays", 32'(bus.state), 32'd3);
        bus.run_sw = 1'b0;
        cyc();
        check("halt_release", 32'(bus.state), 32'd0);
        cyc();
        check("stop_ignores_halt", 32'(bus.state), 32'd0);

        // step with halt_req set lands in HALT
        seen_halt = 0;
        p1        = 0;
        prev_en   = 1'b0;
        bus.step_btn = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 10) bus.step_btn = 1'b0;
            cyc();
            if (prev_en && bus.state == 2'd3) seen_halt++;
            if (bus.cpu_en) p1++;
            prev_en = bus.cpu_en;
        end
        check("step_halt_pulse", 32'(p1), 32'd1);
        check("step_to_halt", 32'(seen_halt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter RATIO, default 2: clock cycles per CPU enable tick in run mode; reset value of the ratio register.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: cycles the synchronized step button must stay stable before it is accepted.
REQ-003 Port clock  in  1  single system clock; all logic on its rising edge.
REQ-004 Port n_reset  in  1  reset, synchronous, active-low.
REQ-005 Port run_sw  in  1  level; 1 requests free-run, 0 requests stop.
REQ-006 Port step_btn  in  1  raw asynchronous pushbutton; a press requests one CPU step.
REQ-007 Port halt_req  in  1  level from CPU (halt instruction retired).
REQ-008 Port ratio_load  in  1  one-cycle strobe; loads ratio_value.
REQ-009 Port ratio_value  in  32  new tick ratio; 0 is treated as 1.
REQ-010 Port cpu_en  out  1  one-cycle enable pulse that advances the CPU.
REQ-011 Port state  out  2  current FSM state, encoded per package enum.

Function
REQ-012 FSM states SHALL be STOP=0, RUN=1, STEP=2, HALT=3.
REQ-013 STOP: cpu_en=0; run_sw=1 -> RUN; else accepted step press -> STEP; halt_req is ignored.
REQ-014 RUN: tick counter counts 0..ratio-1, wraps to 0; cpu_en=1 in exactly the cycle counter==ratio-1.
REQ-015 RUN transition priority: halt_req=1 -> HALT, else run_sw=0 -> STOP, else stay; cpu_en SHALL be 0 in the cycle a transition is taken.
REQ-016 STEP: cpu_en=1 for exactly one cycle; next state HALT if halt_req=1, else STOP.
REQ-017 HALT: cpu_en=0; run_sw=0 -> STOP; step presses ignored.
REQ-018 Tick counter SHALL be held at 0 in every state except RUN; first RUN tick occurs ratio cycles after entering RUN.
REQ-019 ratio_load SHALL update the ratio register and clear the counter in the same cycle, in any state; a tick due that cycle is suppressed.
REQ-020 Step press: step_btn passes a 2-flop synchronizer, then debounce; accepted press = rising edge of the debounced level, one cycle wide.
REQ-021 Held button SHALL yield exactly one press; a press accepted outside STOP is dropped, not queued.
REQ-022 cpu_en SHALL never be 1 in two consecutive cycles when ratio>=2.

Reset
REQ-023 n_reset=0 at a rising edge SHALL force: state=STOP, cpu_en=0, counter=0, ratio=RATIO (0 mapped to 1), synchronizer/debounce flops=0.
REQ-024 Reset mid-RUN or mid-STEP SHALL abort with no cpu_en pulse in the following cycle.
REQ-025 With n_reset=0 held, outputs SHALL remain at reset values regardless of inputs.

Configuration
REQ-026 Macro CPU_STEP_CTRL_DEBOUNCE_EN defined: debounce per REQ-002/REQ-020.
REQ-027 Macro undefined: debounce removed; accepted press = rising edge of synchronizer output; DEBOUNCE_CYCLES unused.

Structure
REQ-028 Package cpu_step_ctrl_pkg SHALL hold state_t enum (2-bit) and the ratio width constant (32).
REQ-029 Sub-module step_debounce (synchronizer, debounce counter, edge detect) SHALL be instantiated once.

Verification
REQ-030 RATIO=2, reset 1 cycle, run_sw=1 -> cpu_en pulses every 2nd cycle, first pulse 2 cycles after RUN entry.
REQ-031 RUN, ratio_load with ratio_value=5 -> counter cleared, next pulse 5 cycles later, then every 5; ratio_value=0 -> pulse every cycle.
REQ-032 STOP, step_btn held high 20 cycles (DEBOUNCE_CYCLES=4) -> exactly one cpu_en pulse, state STOP->STEP->STOP; 1-cycle glitch -> no pulse.
REQ-033 RUN, halt_req=1 and run_sw=0 same cycle -> state HALT, no cpu_en; run_sw stays 0 -> STOP next cycle.
REQ-034 n_reset=0 during RUN on a tick cycle -> next cycle cpu_en=0, state=STOP, counter=0.
REQ-035 Macro undefined: 1-cycle-wide step_btn pulse lasting across a clock edge in STOP -> one cpu_en pulse 3 cycles later.
